// File: rtl/sram_ctrl_pkg.sv
// Shared widths and response payload for the SRAM request front-end.
// Latency: n/a (types only).  Backpressure: n/a.
package sram_ctrl_pkg;

  localparam int SRAM_ADR_W  = 8;
  localparam int SRAM_DAT_W  = 32;
  localparam int SRAM_STRB_W = 4;

  typedef struct packed {
    logic [SRAM_DAT_W-1:0] rdata;
    logic                  write;
  } sram_rsp_t;

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request and response valid/ready channels between a requester and sram_req_ctrl.
// Latency: n/a (wiring only).  Backpressure: io_req_ready / io_rsp_ready.
interface sram_req_ctrl_if;
  import sram_ctrl_pkg::*;

  logic                   io_req_valid;
  logic                   io_req_ready;
  logic [SRAM_ADR_W-1:0]  io_req_bits_addr;
  logic [SRAM_DAT_W-1:0]  io_req_bits_wdata;
  logic [SRAM_STRB_W-1:0] io_req_bits_wstrb;
  logic                   io_req_bits_write;
  logic                   io_rsp_valid;
  logic                   io_rsp_ready;
  logic [SRAM_DAT_W-1:0]  io_rsp_bits_rdata;
  logic                   io_rsp_bits_write;

  modport master (
    output io_req_valid, io_req_bits_addr, io_req_bits_wdata,
           io_req_bits_wstrb, io_req_bits_write, io_rsp_ready,
    input  io_req_ready, io_rsp_valid, io_rsp_bits_rdata, io_rsp_bits_write
  );

  modport slave (
    input  io_req_valid, io_req_bits_addr, io_req_bits_wdata,
           io_req_bits_wstrb, io_req_bits_write, io_rsp_ready,
    output io_req_ready, io_rsp_valid, io_rsp_bits_rdata, io_rsp_bits_write
  );

endinterface

// File: rtl/sram_ctrl_rsp_fifo.sv
// Circular response FIFO holding sram_rsp_t entries; pop_dat reads 0 when empty.
// Latency: push visible on pop_dat the cycle after.  Backpressure: push while full only legal with a same-cycle pop.
module sram_ctrl_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  sram_rsp_t        push_dat,
  input  logic             pop,
  output sram_rsp_t        pop_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sram_rsp_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot first, so a push into a full FIFO is fine alongside it.
  assign do_push = push & (~full | do_pop);
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front-end for the 256x32 SRAM; SRAM_CTRL_WRSP_EN makes writes return responses.
// Latency: 2 cycles request-to-response.  Backpressure: credit-based, io_req_ready independent of io_rsp_ready.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RSP_DEPTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  sram_req_ctrl_if.slave         bus,
  output logic                   io_cen,
  output logic                   io_wen,
  output logic [SRAM_STRB_W-1:0] io_wstrb,
  output logic [SRAM_ADR_W-1:0]  io_adr,
  output logic [SRAM_DAT_W-1:0]  io_d,
  input  logic [SRAM_DAT_W-1:0]  io_q
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic             fire;
  logic             acc_rsp;
  logic             pend_vld;
  logic             pend_wr;
  logic             rsp_pop;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occ;
  logic             fifo_full;
  logic             fifo_empty;
  sram_rsp_t        push_dat;
  sram_rsp_t        head_dat;

  // Reset gates the handshake so the SRAM strobes stay idle whatever the requester does.
  assign fire = bus.io_req_valid & bus.io_req_ready & ~reset;

  assign io_cen   = ~fire;
  assign io_wen   = ~(fire & bus.io_req_bits_write);
  assign io_wstrb = (bus.io_req_bits_write & ~reset) ? bus.io_req_bits_wstrb : '0;
  assign io_adr   = bus.io_req_bits_addr;
  assign io_d     = bus.io_req_bits_wdata;

`ifdef SRAM_CTRL_WRSP_EN
  assign acc_rsp = fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_wr <= 1'b0;
    end else begin
      pend_wr <= fire & bus.io_req_bits_write;
    end
  end
`else
  assign acc_rsp = fire & ~bus.io_req_bits_write;
  assign pend_wr = 1'b0;
`endif

  // pend_vld marks the slot whose io_q (or write token) lands in the FIFO this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_vld <= 1'b0;
    end else begin
      pend_vld <= acc_rsp;
    end
  end

  assign push_dat.rdata = pend_wr ? '0 : io_q;
  assign push_dat.write = pend_wr;

  assign occ              = {1'b0, fifo_count} + (CNT_W + 1)'(pend_vld);
  assign bus.io_req_ready = (occ < (CNT_W + 1)'(RSP_DEPTH));

  assign bus.io_rsp_valid      = ~fifo_empty;
  assign rsp_pop               = bus.io_rsp_valid & bus.io_rsp_ready;
  assign bus.io_rsp_bits_rdata = head_dat.rdata;
  assign bus.io_rsp_bits_write = head_dat.write;

  sram_ctrl_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (pend_vld),
    .push_dat (push_dat),
    .pop      (rsp_pop),
    .pop_dat  (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Credit accounting must never let a pending response hit a full FIFO without a pop.
  assert property (@(posedge clock) disable iff (reset) !(fifo_full && pend_vld && !rsp_pop));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Randomized and directed bench for sram_req_ctrl with a transaction-level reference model.
module tb_sram_req_ctrl;
  import sram_ctrl_pkg::*;

  localparam int RSP_DEPTH = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        write;
    int          t;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_cen;
  logic        io_wen;
  logic [3:0]  io_wstrb;
  logic [7:0]  io_adr;
  logic [31:0] io_d;
  logic [31:0] io_q;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;
  int rsp_seen = 0;

  logic [31:0] sram_mem [256];
  logic [31:0] ref_mem  [256];
  exp_t        exp_q[$];

  sram_req_ctrl_if bus ();

  sram_req_ctrl #(.RSP_DEPTH(RSP_DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .io_cen   (io_cen),
    .io_wen   (io_wen),
    .io_wstrb (io_wstrb),
    .io_adr   (io_adr),
    .io_d     (io_d),
    .io_q     (io_q)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hA5A5A505;
    if (i == 9) return 32'hFFFFFF09;
    return 32'h6B000000 ^ (32'(i) * 32'h00A1B2C3);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // SRAM model: byte-strobed write or registered read on the edge where io_cen is low.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
    end else if (!io_cen) begin
      if (!io_wen) begin
        for (int b = 0; b < 4; b++)
          if (io_wstrb[b]) sram_mem[io_adr][8*b +: 8] <= io_d[8*b +: 8];
      end else begin
        io_q <= sram_mem[io_adr];
      end
    end
  end

  // Reference model: a response is owed per accepted read (and write if enabled), due 2 cycles later.
  always @(negedge clock) begin
    logic exp_rdy, exp_vld, acc;
    exp_t e;
    cyc++;
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      check_eq("rst_cen", io_cen, 1);
      check_eq("rst_wen", io_wen, 1);
      check_eq("rst_wstrb", io_wstrb, 0);
    end else begin
      exp_rdy = (exp_q.size() < RSP_DEPTH);
      exp_vld = (exp_q.size() > 0) && (cyc - exp_q[0].t >= 2);
      acc     = bus.io_req_valid & exp_rdy;
      check_eq("req_ready", bus.io_req_ready, exp_rdy);
      check_eq("rsp_valid", bus.io_rsp_valid, exp_vld);
      check_eq("cen", io_cen, !acc);
      check_eq("wen", io_wen, !(acc & bus.io_req_bits_write));
      check_eq("wstrb", io_wstrb, bus.io_req_bits_write ? bus.io_req_bits_wstrb : 4'h0);
      if (acc) check_eq("adr", io_adr, bus.io_req_bits_addr);
      if (bus.io_rsp_valid && bus.io_rsp_ready) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          check_eq("rsp_stale", bus.io_rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_rdata", bus.io_rsp_bits_rdata, e.rdata);
          check_eq("rsp_write", bus.io_rsp_bits_write, e.write);
        end
      end
      if (acc) begin
        if (bus.io_req_bits_write) begin
          for (int b = 0; b < 4; b++)
            if (bus.io_req_bits_wstrb[b])
              ref_mem[bus.io_req_bits_addr][8*b +: 8] = bus.io_req_bits_wdata[8*b +: 8];
`ifdef SRAM_CTRL_WRSP_EN
          exp_q.push_back('{rdata: 32'h0, write: 1'b1, t: cyc});
`endif
        end else begin
          exp_q.push_back('{rdata: ref_mem[bus.io_req_bits_addr], write: 1'b0, t: cyc});
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    bus.io_req_valid      = v;
    bus.io_req_bits_write = w;
    bus.io_req_bits_addr  = a;
    bus.io_req_bits_wdata = d;
    bus.io_req_bits_wstrb = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int drops;
    int seen0;

    reset = 1'b1;
    bus.io_rsp_ready = 1'b1;
    set_req(1, 1, 8'h07, 32'hDEADBEEF, 4'hF);
    repeat (3) step();
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0);

    @(negedge clock);
    check_eq("rstval_req_ready", bus.io_req_ready, 1);
    check_eq("rstval_rsp_valid", bus.io_rsp_valid, 0);
    check_eq("rstval_rsp_rdata", bus.io_rsp_bits_rdata, 0);
    check_eq("rstval_rsp_write", bus.io_rsp_bits_write, 0);
    check_eq("rstval_cen", io_cen, 1);
    step();

    // Single read of preloaded word: strobe in N only, response in N+2.
    set_req(1, 0, 8'd5, 0, 0);
    @(negedge clock);
    check_eq("t1_cen_n", io_cen, 0);
    step();
    set_req(0, 0, 0, 0, 0);
    @(negedge clock);
    check_eq("t1_cen_n1", io_cen, 1);
    check_eq("t1_vld_n1", bus.io_rsp_valid, 0);
    step();
    @(negedge clock);
    check_eq("t1_vld_n2", bus.io_rsp_valid, 1);
    check_eq("t1_rdata", bus.io_rsp_bits_rdata, 32'hA5A5A505);
    step();
    step();

    // Partial write then back-to-back read of the same word.
    set_req(1, 1, 8'd9, 32'h11223344, 4'b0101);
    step();
    set_req(1, 0, 8'd9, 0, 0);
    step();
    set_req(0, 0, 0, 0, 0);
    @(negedge clock);
`ifdef SRAM_CTRL_WRSP_EN
    check_eq("t2_wrsp_vld", bus.io_rsp_valid, 1);
    check_eq("t2_wrsp_write", bus.io_rsp_bits_write, 1);
    check_eq("t2_wrsp_rdata", bus.io_rsp_bits_rdata, 0);
`else
    check_eq("t2_no_wrsp", bus.io_rsp_valid, 0);
`endif
    step();
    @(negedge clock);
    check_eq("t2_raw_vld", bus.io_rsp_valid, 1);
    check_eq("t2_raw_rdata", bus.io_rsp_bits_rdata, 32'hFF22FF44);
    check_eq("t2_raw_write", bus.io_rsp_bits_write, 0);
    step();
    step();

    // Full backpressure: only RSP_DEPTH reads accepted, then drain in order.
    bus.io_rsp_ready = 1'b0;
    seen0 = rsp_seen;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) set_req(1, 0, 8'(1 + idx), 0, 0);
      else         set_req(0, 0, 0, 0, 0);
      @(negedge clock);
      if (bus.io_req_valid && bus.io_req_ready) idx++;
      step();
    end
    @(negedge clock);
    check_eq("t3_accepted_held", idx, 3);
    check_eq("t3_ready_low", bus.io_req_ready, 0);
    step();
    bus.io_rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) set_req(1, 0, 8'(1 + idx), 0, 0);
      else         set_req(0, 0, 0, 0, 0);
      @(negedge clock);
      if (bus.io_req_valid && bus.io_req_ready) idx++;
      step();
    end
    check_eq("t3_accepted_all", idx, 4);
    check_eq("t3_rsp_count", rsp_seen - seen0, 4);

    // Back-to-back random traffic with the response channel always ready.
    drops = 0;
    for (int c = 0; c < 100; c++) begin
      set_req(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
              $urandom, 4'($urandom_range(0, 15)));
      @(negedge clock);
      if (!bus.io_req_ready) drops++;
      step();
    end
    set_req(0, 0, 0, 0, 0);
    repeat (4) step();
    check_eq("t4_ready_drops", drops, 0);
    check_eq("t4_drained", exp_q.size(), 0);

    // Reset with two responses queued and one read in flight.
    bus.io_rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_req(1, 0, 8'(20 + c), 0, 0);
      step();
    end
    set_req(0, 0, 0, 0, 0);
    @(negedge clock);
    check_eq("t5_pre_rst_vld", bus.io_rsp_valid, 1);
    check_eq("t5_pre_rst_rdy", bus.io_req_ready, 0);
    step();
    reset = 1'b1;
    bus.io_rsp_ready = 1'b1;
    set_req(1, 0, 8'd30, 0, 0);
    step();
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0);
    @(negedge clock);
    check_eq("t5_rsp_valid", bus.io_rsp_valid, 0);
    check_eq("t5_cen", io_cen, 1);
    check_eq("t5_req_ready", bus.io_req_ready, 1);
    seen0 = rsp_seen;
    repeat (6) step();
    check_eq("t5_no_stale", rsp_seen - seen0, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
